// File: rtl/mem_access_unit.sv
// Load/store front end for a byte-addressed big-endian word memory.
// Sub-word stores are done as read-modify-write because the memory only commits full words.
module mem_access_unit #(
    parameter int unsigned MEM_DEPTH = 250000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr_32,
    output logic [31:0] mem_data_out_32,
    input  logic [31:0] mem_data_in_32,
    output logic        mem_rw,
    output logic        mem_en
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic        err_q, err_d;

    logic [31:0] word_addr;
    logic [1:0]  offset;
    logic [32:0] req_last_byte;
    logic        req_err;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign word_addr = {addr_q[31:2], 2'b00};
    assign offset    = addr_q[1:0];

    // Widened by one bit so addresses near 2^32 cannot wrap past the depth check.
    assign req_last_byte = {1'b0, req_addr[31:2], 2'b00} + 33'd3;

    always_comb begin
        req_err = 1'b0;
        if (req_size == SZ_RSVD)
            req_err = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])
            req_err = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if (req_last_byte > 33'(MEM_DEPTH))
            req_err = 1'b1;
    end

    // Lane extraction; offset 0 is the most significant byte.
    always_comb begin
        load_val = word_q;
        case (size_q)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    load_val = {24'd0, word_q[31:24]};
                    2'd1:    load_val = {24'd0, word_q[23:16]};
                    2'd2:    load_val = {24'd0, word_q[15:8]};
                    default: load_val = {24'd0, word_q[7:0]};
                endcase
                if (signed_q && load_val[7])
                    load_val[31:8] = '1;
            end
            SZ_HALF: begin
                load_val = offset[1] ? {16'd0, word_q[15:0]} : {16'd0, word_q[31:16]};
                if (signed_q && load_val[15])
                    load_val[31:16] = '1;
            end
            default: load_val = word_q;
        endcase
    end

    always_comb begin
        merged = word_q;
        case (size_q)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    merged[31:24] = wdata_q[7:0];
                    2'd1:    merged[23:16] = wdata_q[7:0];
                    2'd2:    merged[15:8]  = wdata_q[7:0];
                    default: merged[7:0]   = wdata_q[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1])
                    merged[15:0] = wdata_q[15:0];
                else
                    merged[31:16] = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = req_err;
                    if (req_err)
                        state_d = RESP;
                    else if (req_we && req_size == SZ_WORD)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                word_d  = mem_data_in_32;
                state_d = we_q ? WR : RESP;
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            word_q   <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            err_q    <= err_d;
        end
    end

    // Memory port is a pure decode of registered state, so it never glitches mid-cycle.
    always_comb begin
        mem_en          = 1'b0;
        mem_rw          = 1'b1;
        mem_addr_32     = 32'd0;
        mem_data_out_32 = 32'd0;
        case (state_q)
            RD: begin
                mem_en      = 1'b1;
                mem_addr_32 = word_addr;
            end
            WR: begin
                mem_en          = 1'b1;
                mem_rw          = 1'b0;
                mem_addr_32     = word_addr;
                mem_data_out_32 = merged;
            end
            default: ;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = (state_q == RESP && !we_q && !err_q) ? load_val : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit with a byte-array big-endian memory model.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr_32;
    logic [31:0] mem_data_out_32;
    logic [31:0] mem_data_in_32;
    logic        mem_rw;
    logic        mem_en;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    mem_access_unit #(.MEM_DEPTH(250000)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr_32(mem_addr_32), .mem_data_out_32(mem_data_out_32),
        .mem_data_in_32(mem_data_in_32), .mem_rw(mem_rw), .mem_en(mem_en)
    );

    always #5 clock = ~clock;

    // Memory model: combinational read, write committed at the rising edge.
    logic [7:0]  mem [0:262143];
    logic [17:0] ma;
    logic        bd_we = 1'b0;
    logic [17:0] bd_addr = 18'd0;
    logic [31:0] bd_data = 32'd0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    assign ma = mem_addr_32[17:0];
    assign mem_data_in_32 = {mem[ma], mem[ma + 18'd1], mem[ma + 18'd2], mem[ma + 18'd3]};

    always @(posedge clock) begin
        if (mem_en && !mem_rw) begin
            mem[ma]         <= mem_data_out_32[31:24];
            mem[ma + 18'd1] <= mem_data_out_32[23:16];
            mem[ma + 18'd2] <= mem_data_out_32[15:8];
            mem[ma + 18'd3] <= mem_data_out_32[7:0];
            wr_cnt <= wr_cnt + 1;
        end else if (bd_we) begin
            mem[bd_addr]         <= bd_data[31:24];
            mem[bd_addr + 18'd1] <= bd_data[23:16];
            mem[bd_addr + 18'd2] <= bd_data[15:8];
            mem[bd_addr + 18'd3] <= bd_data[7:0];
        end
        if (mem_en && mem_rw)
            rd_cnt <= rd_cnt + 1;
    end

    function automatic logic [31:0] peek(input logic [17:0] a);
        return {mem[a], mem[a + 18'd1], mem[a + 18'd2], mem[a + 18'd3]};
    endfunction

    task automatic preload(input logic [17:0] a, input logic [31:0] d);
        @(negedge clock);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(negedge clock);
        bd_we   = 1'b0;
    endtask

    // Drives one request, then waits (bounded) for its response; latency counts edges after accept.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic err, output int lat);
        bit got;
        got = 1'b0;
        rd  = 32'd0;
        err = 1'b0;
        lat = 0;
        @(negedge clock);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clock);
            lat++;
            if (resp_valid) begin
                got = 1'b1;
                rd  = resp_rdata;
                err = resp_err;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL resp_timeout addr=%h: no resp_valid within 8 cycles", addr);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        checks += 4;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        if (mem_en !== 1'b0 || mem_rw !== 1'b1) begin
            errors++; $display("FAIL reset_mem_ctl got en=%b rw=%b exp en=0 rw=1", mem_en, mem_rw);
        end
        if (mem_addr_32 !== 32'd0 || mem_data_out_32 !== 32'd0 || resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got addr=%h dout=%h rdata=%h exp all 0", mem_addr_32, mem_data_out_32, resp_rdata);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || mem_en !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got ready=%b en=%b exp ready=1 en=0", req_ready, mem_en);
        end
    endtask

    task automatic test_loads;
        logic [1:0]  sz [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        logic        sg [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad [5] = '{32'h10, 32'h10, 32'h12, 32'h12, 32'h10};
        logic [31:0] ex [5] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFFAABB, 32'h0000AABB, 32'h8899AABB};
        logic [31:0] rd;
        logic        er;
        int          lat, r0, w0;
        exp_t        e;
        preload(18'h10, 32'h8899AABB);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{rdata: ex[i], err: 1'b0, lat: 2});
            r0 = rd_cnt; w0 = wr_cnt;
            issue(1'b0, sz[i], sg[i], ad[i], 32'h0, rd, er, lat);
            e = exp_q.pop_front();
            checks += 2;
            if (rd !== e.rdata || er !== e.err) begin
                errors++; $display("FAIL load_%0d got rdata=%h err=%b exp rdata=%h err=%b", i, rd, er, e.rdata, e.err);
            end
            if (lat != e.lat || rd_cnt - r0 != 1 || wr_cnt != w0) begin
                errors++;
                $display("FAIL load_%0d_timing got lat=%0d reads=%0d writes=%0d exp lat=%0d reads=1 writes=0",
                         i, lat, rd_cnt - r0, wr_cnt - w0, e.lat);
            end
        end
    endtask

    task automatic test_subword_store;
        logic [1:0]  sz [2] = '{2'b00, 2'b01};
        logic [31:0] ad [2] = '{32'h11, 32'h12};
        logic [31:0] wd [2] = '{32'h000000CC, 32'h00001234};
        logic [31:0] mw [2] = '{32'h88CCAABB, 32'h88CC1234};
        logic [31:0] rd;
        logic        er;
        int          lat, r0, w0;
        exp_t        e;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{rdata: 32'd0, err: 1'b0, lat: 3});
            r0 = rd_cnt; w0 = wr_cnt;
            issue(1'b1, sz[i], 1'b0, ad[i], wd[i], rd, er, lat);
            e = exp_q.pop_front();
            checks += 3;
            if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
                errors++; $display("FAIL substore_%0d_resp got rdata=%h err=%b lat=%0d exp 0/0/%0d", i, rd, er, lat, e.lat);
            end
            if (rd_cnt - r0 != 1 || wr_cnt - w0 != 1) begin
                errors++; $display("FAIL substore_%0d_cycles got reads=%0d writes=%0d exp 1/1", i, rd_cnt - r0, wr_cnt - w0);
            end
            if (peek(18'h10) !== mw[i]) begin
                errors++; $display("FAIL substore_%0d_mem got=%h exp=%h", i, peek(18'h10), mw[i]);
            end
        end
    endtask

    task automatic test_word_store;
        logic [31:0] rd;
        logic        er;
        int          lat, r0, w0;
        exp_t        e;
        exp_q.push_back('{rdata: 32'd0, err: 1'b0, lat: 2});
        r0 = rd_cnt; w0 = wr_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, rd, er, lat);
        e = exp_q.pop_front();
        checks += 3;
        if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
            errors++; $display("FAIL sw_resp got rdata=%h err=%b lat=%0d exp 0/0/%0d", rd, er, lat, e.lat);
        end
        if (rd_cnt != r0 || wr_cnt - w0 != 1) begin
            errors++; $display("FAIL sw_cycles got reads=%0d writes=%0d exp 0/1", rd_cnt - r0, wr_cnt - w0);
        end
        if (mem[32'h20] !== 8'hDE || mem[32'h21] !== 8'hAD || mem[32'h22] !== 8'hBE || mem[32'h23] !== 8'hEF) begin
            errors++; $display("FAIL sw_bytes got=%h exp=deadbeef", peek(18'h20));
        end
    endtask

    task automatic test_errors;
        logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        logic [31:0] ad [4] = '{32'h13, 32'h22, 32'h10, 32'h3D090};
        logic [31:0] rd;
        logic        er;
        int          lat, n0;
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{rdata: 32'd0, err: 1'b1, lat: 1});
            n0 = rd_cnt + wr_cnt;
            issue(1'b0, sz[i], 1'b0, ad[i], 32'h0, rd, er, lat);
            e = exp_q.pop_front();
            checks += 2;
            if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
                errors++; $display("FAIL err_%0d_resp got rdata=%h err=%b lat=%0d exp 0/1/1", i, rd, er, lat);
            end
            if (rd_cnt + wr_cnt != n0) begin
                errors++; $display("FAIL err_%0d_mem_en got accesses=%0d exp 0", i, rd_cnt + wr_cnt - n0);
            end
        end
        preload(18'h3D08C, 32'h11223344);
        exp_q.push_back('{rdata: 32'h11223344, err: 1'b0, lat: 2});
        issue(1'b0, 2'b10, 1'b0, 32'h3D08C, 32'h0, rd, er, lat);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
            errors++; $display("FAIL last_word got rdata=%h err=%b lat=%0d exp %h/0/2", rd, er, lat, e.rdata);
        end
    endtask

    task automatic test_reset_mid_write;
        bit saw;
        int w0;
        saw = 1'b0;
        preload(18'h40, 32'h01020304);
        w0 = wr_cnt;
        @(negedge clock);
        req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        checks++;
        if (mem_en !== 1'b1 || mem_rw !== 1'b0) begin
            errors++; $display("FAIL mid_wr_setup got en=%b rw=%b exp en=1 rw=0", mem_en, mem_rw);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_en !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL mid_wr_abort got en=%b ready=%b exp en=0 ready=1", mem_en, req_ready);
        end
        repeat (2) begin @(negedge clock); if (resp_valid) saw = 1'b1; end
        reset = 1'b0;
        repeat (3) begin @(negedge clock); if (resp_valid) saw = 1'b1; end
        checks += 2;
        if (saw) begin errors++; $display("FAIL mid_wr_resp got resp_valid=1 exp none"); end
        if (peek(18'h40) !== 32'h01020304 || wr_cnt != w0) begin
            errors++; $display("FAIL mid_wr_mem got=%h writes=%0d exp=01020304 writes=0", peek(18'h40), wr_cnt - w0);
        end
    endtask

    task automatic test_back_to_back;
        int pushed, popped;
        exp_t e;
        pushed = 0;
        popped = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (resp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected got rdata=%h exp no response", resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                        errors++; $display("FAIL b2b_resp_%0d got rdata=%h err=%b exp rdata=%h err=%b",
                                           popped, resp_rdata, resp_err, e.rdata, e.err);
                    end
                end
            end
            req_valid = 1'b1;
            req_we    = 1'b0;
            if (c % 2 == 0) begin
                req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10;
            end else begin
                req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h11;
            end
            if (req_ready) begin
                exp_q.push_back('{rdata: (c % 2 == 0) ? 32'h88CC1234 : 32'h000000CC, err: 1'b0, lat: 2});
                pushed++;
            end
        end
        req_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (resp_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                popped++;
                checks++;
                if (resp_rdata !== e.rdata) begin
                    errors++; $display("FAIL b2b_drain got rdata=%h exp=%h", resp_rdata, e.rdata);
                end
            end
        end
        checks++;
        if (pushed != popped || pushed < 8) begin
            errors++; $display("FAIL b2b_count got accepted=%0d responded=%0d exp equal and >=8", pushed, popped);
        end
    endtask

    initial begin
        test_reset;
        test_loads;
        test_subword_store;
        test_word_store;
        test_errors;
        test_reset_mid_write;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
